// File: rtl/buffer_arb_pkg.sv
// Shared types and helpers for the buffer round-robin arbiter and its picker.
// Latency: none (definitions only).
// Backpressure: n/a.
//
// Contents: state_t (arbiter FSM states), DATA_W_DEF / N_REQ_MAX
// (parameter defaults and limits), onehot() index-to-one-hot helper.
package buffer_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int N_REQ_MAX  = 8;

    // Callers slice the low N_REQ bits of the result.
    function automatic logic [N_REQ_MAX-1:0] onehot(input int unsigned idx);
        logic [N_REQ_MAX-1:0] one;
        one = {{(N_REQ_MAX-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr+1 upward, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the pick.
//
// Ports:
//   req      in   N_REQ  request vector
//   ptr      in   PTR_W  index of the last winner (search starts one above it)
//   pick_idx out  PTR_W  index of the chosen requester (0 when pick_vld=0)
//   pick_vld out  1      at least one request was set
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] pick_idx,
    output logic             pick_vld
);

    // Offsets 1..N_REQ visit every requester once, the previous winner last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_vld && req[(int'(ptr) + k) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/buffer_rr_arbiter.sv
// Round-robin, packet-locked arbiter feeding one registered valid/ready output word.
// Latency: request in IDLE -> grant at edge 1 -> first word on out_* at edge 2; one idle cycle between packets.
// Backpressure: only the granted requester sees in_ready = !out_valid || out_ready; all others see 0.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data/valid/last per-requester word (requester i at [i*DATA_W +: DATA_W]), valid, end-of-packet
//   in_ready           per-requester ready, one-hot or zero
//   out_data/valid/last/ready  registered output stage
//   grant              registered one-hot grant, zero while idle
//   busy               high while a packet holds the stage
//   grant_cnt          (only with BUFFER_ARB_GRANT_CNT_EN) saturating 16-bit grant count per requester
module buffer_rr_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ-1:0]        in_last,
    output logic [N_REQ-1:0]        in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy
`ifdef BUFFER_ARB_GRANT_CNT_EN
    ,
    output logic [N_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     gidx;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic                 accept;
    logic                 xfer;
    logic                 xfer_last;
    logic                 arb_win;
    logic [N_REQ_MAX-1:0] pick_oh;
    logic [N_REQ_MAX-1:0] gidx_oh;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req      (in_valid),
        .ptr      (ptr),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Stage can take a word when empty or when its word leaves this cycle.
    assign accept    = !out_valid || out_ready;
    assign xfer      = (state == ST_LOCKED) && in_valid[gidx] && accept;
    assign xfer_last = xfer && in_last[gidx];
    assign arb_win   = (state == ST_IDLE) && pick_vld;
    assign pick_oh   = onehot(32'(pick_idx));
    assign gidx_oh   = onehot(32'(gidx));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pick_vld)  state_nxt = ST_LOCKED;
            ST_LOCKED: if (xfer_last) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = '0;
        busy     = (state == ST_LOCKED);
        if (state == ST_LOCKED && accept) begin
            in_ready = gidx_oh[N_REQ-1:0];
        end
    end

    // Grant bookkeeping; ptr only moves when a packet completes, so the
    // requester that just finished is searched last next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= '0;
            gidx  <= '0;
            ptr   <= PTR_W'(N_REQ - 1);
        end else if (arb_win) begin
            grant <= pick_oh[N_REQ-1:0];
            gidx  <= pick_idx;
        end else if (xfer_last) begin
            grant <= '0;
            ptr   <= gidx;
        end
    end

    // Output word; a load in the same cycle as a drain keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= in_data[gidx*DATA_W +: DATA_W];
            out_last  <= in_last[gidx];
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BUFFER_ARB_GRANT_CNT_EN
    logic [15:0] cnt [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (arb_win && cnt[pick_idx] != 16'hFFFF) begin
            cnt[pick_idx] <= cnt[pick_idx] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
        assign grant_cnt[gi*16 +: 16] = cnt[gi];
    end
`endif

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
module tb_buffer_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready = 1'b1;
    logic [N-1:0]   grant;
    logic           busy;
`ifdef BUFFER_ARB_GRANT_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    buffer_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
`ifdef BUFFER_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-requester pending words: bit 16 = last, bits 15:0 = data.
    logic [16:0] wq [N][$];
    logic [15:0] got [$];

    // Reference model: who owns the stage, where the search starts, and
    // the single word held in the output stage.
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          m_ov;
    logic [15:0] m_od;
    bit          m_ol;
    int          m_cnt [N];

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = N - 1;
        m_ov = 0; m_od = '0; m_ol = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit found;
        int i;
        acc = !m_ov || out_ready;
        if (!m_locked) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                i = (m_ptr + k) % N;
                if (!found && in_valid[i]) begin
                    found = 1; m_locked = 1; m_owner = i;
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                end
            end
            if (m_ov && out_ready) m_ov = 0;
        end else if (in_valid[m_owner] && acc) begin
            m_od = in_data[m_owner*W +: W];
            m_ol = in_last[m_owner];
            m_ov = 1;
            if (m_ol) begin
                m_locked = 0;
                m_ptr = m_owner;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (wq[i].size() > 0) begin
                in_valid[i]         = 1'b1;
                in_data[i*W +: W]   = wq[i][0][15:0];
                in_last[i]          = wq[i][0][16];
            end else begin
                in_valid[i]         = 1'b0;
                in_data[i*W +: W]   = '0;
                in_last[i]          = 1'b0;
            end
        end
    endtask

    // One clock: drive from queues, compare against the model at negedge,
    // advance the model, pop words that were handshaked.
    task automatic cycle();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_rdy;
        logic [N-1:0] hs;
        drive();
        @(negedge clk);
        e_grant = m_locked ? N'(1 << m_owner) : '0;
        e_rdy   = (m_locked && (!m_ov || out_ready)) ? N'(1 << m_owner) : '0;
        chk("grant",     64'(grant),     64'(e_grant));
        chk("in_ready",  64'(in_ready),  64'(e_rdy));
        chk("busy",      64'(busy),      64'(m_locked));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data",  64'(out_data),  64'(m_od));
        chk("out_last",  64'(out_last),  64'(m_ol));
`ifdef BUFFER_ARB_GRANT_CNT_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        hs = in_valid & e_rdy;
        if (out_valid && out_ready) got.push_back(out_data);
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) void'(wq[i].pop_front());
    endtask

    // Reset pulse of one cycle, checked while rst_n is low.
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_grant",     64'(grant),     64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) wq[i].delete();
        got.delete();
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic        ordy;
        logic [3:0]  e_grant;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [15:0] e_od;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [15:0] held;

        // All four requesters continuously offer a single-word packet.
        tbl[0] = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 16'h0000};
        tbl[1] = '{4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b0, 16'h0000};
        tbl[2] = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1, 16'hA000};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 4'h2, 4'h2, 1'b0, 16'hA000};
        tbl[4] = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1, 16'hA001};
        tbl[5] = '{4'hF, 4'hF, 1'b1, 4'h4, 4'h4, 1'b0, 16'hA001};
        tbl[6] = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1, 16'hA002};
        tbl[7] = '{4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b0, 16'hA002};
        tbl[8] = '{4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1, 16'hA003};
        tbl[9] = '{4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 1'b0, 16'hA003};

        #1;
        do_reset();

        // Round-robin fairness table.
        in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        for (int v = 0; v < 10; v++) begin
            in_valid  = tbl[v].vld;
            in_last   = tbl[v].lst;
            out_ready = tbl[v].ordy;
            @(negedge clk);
            chk("tbl_grant",     64'(grant),     64'(tbl[v].e_grant));
            chk("tbl_in_ready",  64'(in_ready),  64'(tbl[v].e_rdy));
            chk("tbl_out_valid", 64'(out_valid), 64'(tbl[v].e_ov));
            chk("tbl_out_data",  64'(out_data),  64'(tbl[v].e_od));
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a packet from requester 1.
        clear_q();
        do_reset();
        out_ready = 1'b1;
        wq[1].push_back({1'b0, 16'h0101});
        wq[1].push_back({1'b0, 16'h0102});
        wq[1].push_back({1'b1, 16'h0103});
        cycle();
        cycle();
        chk("midpkt_grant", 64'(grant), 64'(4'b0010));
        do_reset();
        cycle();
        chk("rearb_grant", 64'(grant), 64'(4'b0010));
        for (int c = 0; c < 6; c++) cycle();

        // Packet lock: req0's three words precede req2's word.
        clear_q();
        do_reset();
        wq[0].push_back({1'b0, 16'h1111});
        wq[0].push_back({1'b0, 16'h2222});
        wq[0].push_back({1'b1, 16'h3333});
        wq[2].push_back({1'b1, 16'h5555});
        for (int c = 0; c < 12; c++) cycle();
        chk("lock_count", 64'(got.size()), 64'(4));
        if (got.size() == 4) begin
            chk("lock_w0", 64'(got[0]), 64'(16'h1111));
            chk("lock_w1", 64'(got[1]), 64'(16'h2222));
            chk("lock_w2", 64'(got[2]), 64'(16'h3333));
            chk("lock_w3", 64'(got[3]), 64'(16'h5555));
        end

        // Backpressure: stalled word stays put, then load and drain coincide.
        clear_q();
        do_reset();
        out_ready = 1'b1;
        wq[0].push_back({1'b0, 16'h0C01});
        wq[0].push_back({1'b0, 16'h0C02});
        wq[0].push_back({1'b1, 16'h0C03});
        cycle();
        cycle();
        chk("bp_loaded", 64'(out_data), 64'(16'h0C01));
        held = out_data;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_hold_data",  64'(out_data),  64'(held));
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_reload_valid", 64'(out_valid), 64'(1));
        chk("bp_reload_data",  64'(out_data),  64'(16'h0C02));
        for (int c = 0; c < 4; c++) cycle();

        // Idle gap: lone single-word packet from req3.
        clear_q();
        do_reset();
        wq[3].push_back({1'b1, 16'hBEEF});
        cycle();
        chk("gap_e1_grant", 64'(grant),     64'(4'b1000));
        chk("gap_e1_ov",    64'(out_valid), 64'(0));
        cycle();
        chk("gap_e2_ov",    64'(out_valid), 64'(1));
        chk("gap_e2_data",  64'(out_data),  64'(16'hBEEF));
        chk("gap_e2_last",  64'(out_last),  64'(1));
        chk("gap_e2_grant", 64'(grant),     64'(0));
        chk("gap_e2_busy",  64'(busy),      64'(0));
        cycle();
        chk("gap_e3_ov",    64'(out_valid), 64'(0));
        cycle();
        chk("gap_e4_ov",    64'(out_valid), 64'(0));
        chk("gap_e4_grant", 64'(grant),     64'(0));

`ifdef BUFFER_ARB_GRANT_CNT_EN
        clear_q();
        do_reset();
        for (int p = 0; p < 5; p++) wq[1].push_back({1'b1, 16'(16'h1000 + p)});
        for (int p = 0; p < 2; p++) wq[2].push_back({1'b1, 16'(16'h2000 + p)});
        for (int c = 0; c < 30; c++) cycle();
        chk("cnt_req1", 64'(grant_cnt[16 +: 16]), 64'(5));
        chk("cnt_req2", 64'(grant_cnt[32 +: 16]), 64'(2));
`endif

        // Randomised traffic against the model.
        clear_q();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (wq[i].size() == 0 && $urandom_range(3) == 0) begin
                    int len;
                    len = int'($urandom_range(4, 1));
                    for (int w = 0; w < len; w++) begin
                        wq[i].push_back({(w == len - 1), 16'($urandom)});
                    end
                end
            end
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
